monitor_slot_host: RTL

//  Initiator (monitor side) of the BKM-68X option-slot bus: slot select, clk_rw strobe,
//  ax_d address/data phase, r_wx direction, 8-bit shared ad bus and card IRQ.

---
 rtl/monitor_slot_host.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/monitor_slot_host.sv
// Host (monitor-side) initiator for the BKM-68X option-slot bus: turns single register
// read/write commands into timed slot bus cycles and returns read data, plus a sticky card IRQ flag.
module monitor_slot_host #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int TURN_CYC   = 2
) (
  input  logic       clk_50mhz_in,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       slot_sel,
  output logic       clk_rw,
  output logic       ax_d,
  output logic       r_wx,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  input  logic       irq_n,
  output logic       irq_pending,
  input  logic       irq_ack,
  output logic [3:0] dbg_state
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SETUP_RELOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_RELOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_RELOAD   = CNT_W'(TURN_CYC - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_A_SETUP  = 4'd1,
    ST_A_STROBE = 4'd2,
    ST_A_HOLD   = 4'd3,
    ST_TURN     = 4'd4,
    ST_D_SETUP  = 4'd5,
    ST_D_STROBE = 4'd6,
    ST_D_HOLD   = 4'd7,
    ST_DONE     = 4'd8
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             read_q;
  logic [7:0]       wdata_q;
  logic             slot_sel_q;
  logic             clk_rw_q;
  logic             ax_d_q;
  logic             r_wx_q;
  logic [7:0]       ad_out_q;
  logic             ad_oe_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_rdata_q;
  logic             phase_end;

  assign phase_end = (cnt_q == '0);

  // Handshake: a command is taken on a cycle where cmd_valid and cmd_ready are both high;
  // cmd_ready is high only while idle, so the command fields need only be stable on that edge.
  assign cmd_ready = (state_q == ST_IDLE);
  assign dbg_state = state_q;

  // Every bus output is registered and changes on the edge that enters the next phase,
  // so clk_rw can never toggle in the same cycle as ax_d or ad_out.
  always_ff @(posedge clk_50mhz_in or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      read_q      <= 1'b0;
      wdata_q     <= 8'h00;
      slot_sel_q  <= 1'b0;
      clk_rw_q    <= 1'b0;
      ax_d_q      <= 1'b0;
      r_wx_q      <= 1'b0;
      ad_out_q    <= 8'h00;
      ad_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      rsp_valid_q <= 1'b0;
      if (!phase_end) cnt_q <= cnt_q - CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_q    <= ST_A_SETUP;
            cnt_q      <= SETUP_RELOAD;
            read_q     <= cmd_read;
            wdata_q    <= cmd_wdata;
            slot_sel_q <= 1'b1;
            ax_d_q     <= 1'b1;
            ad_oe_q    <= 1'b1;
            ad_out_q   <= cmd_addr;
          end
        end
        ST_A_SETUP: begin
          if (phase_end) begin
            state_q  <= ST_A_STROBE;
            cnt_q    <= STROBE_RELOAD;
            clk_rw_q <= 1'b1;
          end
        end
        ST_A_STROBE: begin
          if (phase_end) begin
            state_q  <= ST_A_HOLD;
            cnt_q    <= HOLD_RELOAD;
            clk_rw_q <= 1'b0;
          end
        end
        ST_A_HOLD: begin
          if (phase_end) begin
            ax_d_q <= 1'b0;
            if (read_q) begin
              // Release ad before the card may drive it; r_wx rises in the same edge.
              state_q  <= ST_TURN;
              cnt_q    <= TURN_RELOAD;
              ad_oe_q  <= 1'b0;
              r_wx_q   <= 1'b1;
              ad_out_q <= 8'h00;
            end else begin
              state_q  <= ST_D_SETUP;
              cnt_q    <= SETUP_RELOAD;
              ad_out_q <= wdata_q;
            end
          end
        end
        ST_TURN: begin
          if (phase_end) begin
            state_q <= ST_D_SETUP;
            cnt_q   <= SETUP_RELOAD;
          end
        end
        ST_D_SETUP: begin
          if (phase_end) begin
            state_q  <= ST_D_STROBE;
            cnt_q    <= STROBE_RELOAD;
            clk_rw_q <= 1'b1;
          end
        end
        ST_D_STROBE: begin
          if (phase_end) begin
            state_q  <= ST_D_HOLD;
            cnt_q    <= HOLD_RELOAD;
            clk_rw_q <= 1'b0;
            if (read_q) rsp_rdata_q <= ad_in;
          end
        end
        ST_D_HOLD: begin
          if (phase_end) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
            slot_sel_q  <= 1'b0;
            ax_d_q      <= 1'b0;
            r_wx_q      <= 1'b0;
            ad_oe_q     <= 1'b0;
            ad_out_q    <= 8'h00;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign slot_sel  = slot_sel_q;
  assign clk_rw    = clk_rw_q;
  assign ax_d      = ax_d_q;
  assign r_wx      = r_wx_q;
  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // irq_n is asynchronous: two sync stages, then a third flop remembers the previous
  // synchronized level so only a fresh falling edge can set the flag.
  logic irq_s1_q;
  logic irq_s2_q;
  logic irq_prev_q;
  logic irq_pending_q;
  logic irq_pending_d;
  logic irq_fall;

  assign irq_fall = irq_prev_q & ~irq_s2_q;

  always_comb begin
    irq_pending_d = irq_pending_q;
    if (irq_ack)  irq_pending_d = 1'b0;
    if (irq_fall) irq_pending_d = 1'b1;
  end

  always_ff @(posedge clk_50mhz_in or posedge reset) begin
    if (reset) begin
      irq_s1_q      <= 1'b1;
      irq_s2_q      <= 1'b1;
      irq_prev_q    <= 1'b1;
      irq_pending_q <= 1'b0;
    end else begin
      irq_s1_q      <= irq_n;
      irq_s2_q      <= irq_s1_q;
      irq_prev_q    <= irq_s2_q;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign irq_pending = irq_pending_q;

endmodule
